multicycle_sequencer: RTL and testbench

//  Multicycle main FSM, directly downstream of the combinational decoder.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/multicycle_sequencer_watchdog.sv | 30 +++
 rtl/multicycle_sequencer.sv | 150 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control path: FSM state encodings,
// PC source select codes and the decoder flags held across an instruction.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_ERROR     = 3'd7
    } state_t;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
    } flags_t;

endpackage

// File: rtl/multicycle_sequencer_watchdog.sv
// Memory-wait watchdog: counts consecutive not-ready cycles in a wait state
// and flags expiry when the limit is reached without a ready.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expire
);

    localparam int unsigned    W     = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0]   LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] wait_cnt;

    // Cleared outside wait states and on ready, so every FETCH/MEMORY entry
    // (including MEMORY straight into FETCH) starts from zero.
    always_ff @(posedge clk) begin
        if (reset || !active || ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expire = active && !ready && (wait_cnt == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle main control FSM: steps each decoded instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       pc_sel,
    output logic             regWriteEn,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             error
);

    state_t state_q, state_d;
    flags_t flags_q;
    logic   wd_active, wd_ready, wd_expire;

    assign wd_active = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
    assign wd_ready  = (state_q == ST_FETCH) ? imem_ready : dmem_ready;

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) wd (
        .clk    (clk),
        .reset  (reset),
        .active (wd_active),
        .ready  (wd_ready),
        .expire (wd_expire)
    );

    // Jump is acted on in DECODE itself, so only the flags needed later are held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            flags_q <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                flags_q <= {RegWrite, MemRead, MemWrite, Branch};
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        pc_sel     = PC_SEL_INC;
        regWriteEn = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (Jump) begin
                    PCWrite = 1'b1;
                    pc_sel  = PC_SEL_JMP;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (flags_q.branch) begin
                    PCWrite = zero;
                    pc_sel  = PC_SEL_BR;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (flags_q.memread || flags_q.memwrite) begin
                    state_d = ST_MEMORY;
                end else if (flags_q.regwrite) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = flags_q.memwrite && !flags_q.memread;
                if (dmem_ready) begin
                    if (flags_q.memread) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (wd_expire) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITEBACK: begin
                regWriteEn = flags_q.regwrite;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
        if (reset) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            regWriteEn = 1'b0;
            retire     = 1'b0;
        end
    end

    assign state = state_q;
    assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-instruction expectations are
// queued at issue time and checked by an independent monitor on each retire.
module tb_multicycle_sequencer;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic             Branch = 1'b0, Jump = 1'b0, zero = 1'b0;
    logic             imem_ready = 1'b0, dmem_ready = 1'b0;
    logic             imem_req, dmem_req, dmem_we, IRWrite, PCWrite;
    logic [1:0]       pc_sel;
    logic             regWriteEn, retire, error;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .Jump       (Jump),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .pc_sel     (pc_sel),
        .regWriteEn (regWriteEn),
        .state      (state),
        .retire     (retire),
        .instret    (instret),
        .error      (error)
    );

    typedef struct {
        int unsigned cycles;
        int unsigned dcyc;
        int unsigned wecyc;
        int unsigned irw;
        int unsigned pcw;
        int unsigned rwe;
        int          pcsel;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned model_ret = 0;
    bit          mon_en = 1'b0;
    bit          aborted = 1'b0;
    int          mode = 0;      // 0 normal memory, 1 imem never ready, 2 both always ready
    int unsigned imem_wait = 0;
    int unsigned dmem_wait = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: cycle cost and strobe counts of one instruction from its flags.
    function automatic exp_t model(input bit rw, mr, mw, br, j, z,
                                   input int unsigned iw, dw);
        exp_t e;
        e.cycles = iw + 2;
        e.dcyc   = 0;
        e.wecyc  = 0;
        e.irw    = 1;
        e.pcw    = 1;
        e.rwe    = 0;
        e.pcsel  = -1;
        if (j) begin
            e.pcw   = 2;
            e.pcsel = 2;
        end else begin
            e.cycles += 1;
            if (br) begin
                e.pcw  += z ? 1 : 0;
                e.pcsel = 1;
            end else if (mr || mw) begin
                e.dcyc    = dw + 1;
                e.cycles += dw + 1;
                if (mr) begin
                    e.cycles += 1;
                    e.rwe     = rw ? 1 : 0;
                end else begin
                    e.wecyc = dw + 1;
                end
            end else if (rw) begin
                e.cycles += 1;
                e.rwe     = 1;
            end
        end
        return e;
    endfunction

    task automatic issue(input bit rw, mr, mw, br, j, z, input int unsigned iw, dw);
        bit got;
        got = 1'b0;
        if (aborted) return;
        sb.push_back(model(rw, mr, mw, br, j, z, iw, dw));
        RegWrite  = rw;
        MemRead   = mr;
        MemWrite  = mw;
        Branch    = br;
        Jump      = j;
        zero      = z;
        imem_wait = iw;
        dmem_wait = dw;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (retire === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL retire_timeout: got no retire expected one within 400 cycles");
            aborted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Memory responder: answers each request after the programmed number of
    // wait cycles, and drives noise on a ready whose request is idle.
    initial begin
        int unsigned icnt, dcnt;
        icnt = 0;
        dcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 1) begin
                imem_ready = 1'b0;
                dmem_ready = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                imem_ready = 1'b1;
                dmem_ready = 1'b1;
            end else begin
                if (imem_req === 1'b1) begin
                    imem_ready = (icnt == imem_wait);
                    icnt       = imem_ready ? 0 : icnt + 1;
                end else begin
                    imem_ready = 1'($urandom_range(0, 1));
                    icnt       = 0;
                end
                if (dmem_req === 1'b1) begin
                    dmem_ready = (dcnt == dmem_wait);
                    dcnt       = dmem_ready ? 0 : dcnt + 1;
                end else begin
                    dmem_ready = 1'($urandom_range(0, 1));
                    dcnt       = 0;
                end
            end
        end
    end

    // Monitor: accumulates strobes per instruction and checks them on retire.
    initial begin
        int unsigned cyc, dc, wc, irw, pcw, rwe;
        exp_t e;
        cyc = 0; dc = 0; wc = 0; irw = 0; pcw = 0; rwe = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                cyc = 0; dc = 0; wc = 0; irw = 0; pcw = 0; rwe = 0;
                continue;
            end
            cyc++;
            if (dmem_req === 1'b1) dc++;
            if (dmem_req === 1'b1 && dmem_we === 1'b1) wc++;
            if (IRWrite === 1'b1) irw++;
            if (PCWrite === 1'b1) pcw++;
            if (regWriteEn === 1'b1) rwe++;
            if (retire === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_retire: got retire expected none (state %0d)", state);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(cyc), 64'(e.cycles));
                    chk("dmem_req_cycles", 64'(dc), 64'(e.dcyc));
                    chk("dmem_we_cycles", 64'(wc), 64'(e.wecyc));
                    chk("irwrite_pulses", 64'(irw), 64'(e.irw));
                    chk("pcwrite_pulses", 64'(pcw), 64'(e.pcw));
                    chk("regwe_pulses", 64'(rwe), 64'(e.rwe));
                    if (e.pcsel >= 0) chk("pc_sel", 64'(pc_sel), 64'(e.pcsel));
                    chk("instret", 64'(instret), 64'(model_ret));
                    chk("error_low", 64'(error), 64'd0);
                    model_ret++;
                end
                cyc = 0; dc = 0; wc = 0; irw = 0; pcw = 0; rwe = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no completion expected finish before time limit");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        int unsigned fc;
        bit          hit;
        int unsigned kind, iw, dw;
        bit          rw, mr, mw, br, j, z;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_instret", 64'(instret), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        chk("reset_strobes", 64'({imem_req, dmem_req, dmem_we, IRWrite, PCWrite, regWriteEn, retire}), 64'd0);

        reset  = 1'b0;
        mon_en = 1'b1;

        issue(1, 0, 0, 0, 0, 0, 0, 0);   // ADD
        issue(1, 1, 0, 0, 0, 0, 0, 3);   // LW, 3 wait cycles
        issue(0, 0, 1, 0, 0, 0, 0, 0);   // SW
        issue(0, 0, 0, 1, 0, 1, 0, 0);   // BEQ taken
        issue(0, 0, 0, 1, 0, 0, 0, 0);   // BEQ not taken
        issue(0, 0, 0, 0, 1, 0, 0, 0);   // J
        issue(0, 0, 0, 0, 0, 0, 1, 0);   // no flags
        issue(1, 1, 1, 0, 0, 0, 2, 1);   // read+write treated as read
        issue(1, 1, 1, 1, 0, 0, 0, 0);   // branch beats memory
        issue(1, 1, 1, 1, 1, 1, 0, 0);   // jump beats everything
        issue(1, 0, 0, 0, 0, 0, MEM_TIMEOUT - 1, 0);   // ready on the last allowed cycle
        issue(1, 1, 0, 0, 0, 0, 0, MEM_TIMEOUT - 1);
        issue(0, 0, 1, 0, 0, 0, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1);

        for (int n = 0; n < 150 && !aborted; n++) begin
            kind = $urandom_range(0, 5);
            iw   = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : $urandom_range(0, 3);
            dw   = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : $urandom_range(0, 3);
            z    = 1'($urandom_range(0, 1));
            {rw, mr, mw, br, j} = 5'b0;
            case (kind)
                0: rw = 1'b1;
                1: {rw, mr} = 2'b11;
                2: mw = 1'b1;
                3: br = 1'b1;
                4: j = 1'b1;
                default: {rw, mr, mw, br, j} = 5'($urandom_range(0, 31));
            endcase
            issue(rw, mr, mw, br, j, z, iw, dw);
        end

        if (!aborted) begin
            chk("scoreboard_drained", 64'(sb.size()), 64'd0);
            mon_en = 1'b0;

            // Reset while a store is waiting on data memory.
            RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b1; Branch = 1'b0; Jump = 1'b0;
            imem_wait = 0;
            dmem_wait = 10;
            hit = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (state === 3'd3) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reached_memory", 64'(hit), 64'd1);
            chk("sw_dmem_req", 64'(dmem_req), 64'd1);
            chk("sw_dmem_we", 64'(dmem_we), 64'd1);
            @(posedge clk);
            #1;
            reset = 1'b1;
            #1;
            chk("midreset_strobes", 64'({imem_req, dmem_req, dmem_we, IRWrite, PCWrite, regWriteEn, retire}), 64'd0);
            @(posedge clk);
            #1;
            chk("midreset_state", 64'(state), 64'd0);
            chk("midreset_instret", 64'(instret), 64'd0);

            // Instruction memory never answers: watchdog must trip.
            mode  = 1;
            reset = 1'b0;
            fc    = 0;
            hit   = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (state === 3'd7) begin
                    hit = 1'b1;
                    break;
                end
                if (state === 3'd0) fc++;
            end
            chk("watchdog_tripped", 64'(hit), 64'd1);
            chk("fetch_wait_cycles", 64'(fc), 64'(MEM_TIMEOUT));
            mode = 2;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("error_sticky", 64'(error), 64'd1);
                chk("error_state", 64'(state), 64'd7);
                chk("error_strobes", 64'({imem_req, dmem_req, dmem_we, IRWrite, PCWrite, regWriteEn, retire}), 64'd0);
            end
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("recover_state", 64'(state), 64'd0);
            chk("recover_error", 64'(error), 64'd0);
            reset = 1'b0;
            mode  = 0;
            @(negedge clk);
            chk("recover_fetch_req", 64'(imem_req), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
